// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and alignment check shared by the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_BAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    // An access is rejected when its size is illegal or it is not naturally aligned
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_BAD) || (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane steering for store data/byte enables and load extraction/extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Store path: replicate narrow data across the word, enable only the addressed bytes
    always_comb begin
        wdata_o = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
        wmask_o = size_i == SZ_B ? 4'b0001 << lane_i : size_i == SZ_H ? (lane_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // Load path: move the addressed byte/half down to bit 0, then sign- or zero-extend
    always_comb begin
        shifted = raw_i >> {lane_i, 3'b000};
        rdata_o = size_i == SZ_B ? {{24{~uns_i & shifted[7]}}, shifted[7:0]}
                : size_i == SZ_H ? {{16{~uns_i & shifted[15]}}, shifted[15:0]}
                : raw_i;
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between core control and a 32-bit data memory port
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("lsu: DATA_W must be 32");
    end

    state_e            state_q, state_d;
    logic              wen_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [DATA_W-1:0] al_wdata, al_rdata;
    logic [3:0]        al_wmask;
    logic              accept, bad;

    assign accept = req_valid & req_ready;
    assign bad    = misaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .size_i  (size_q),
        .lane_i  (addr_q[1:0]),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .raw_i   (mem_rdata),
        .wdata_o (al_wdata),
        .wmask_o (al_wmask),
        .rdata_o (al_rdata)
    );

    // Next-state and handshake decode; errored requests skip memory entirely
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = bad ? RESP : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: if (mem_resp_valid) state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request capture at the handshake and result capture on the memory response
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wen_q   <= req_wen;
                uns_q   <= req_unsigned;
                err_q   <= bad;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (bad) rdata_q <= '0;
            end
            if (state_q == WAIT && mem_resp_valid) rdata_q <= wen_q ? '0 : al_rdata;
        end
    end

    assign mem_addr  = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wen   = mem_req_valid & wen_q;
    assign mem_wdata = mem_wen ? al_wdata : '0;
    assign mem_wmask = mem_wen ? al_wmask : 4'b0000;
    assign rdata     = rdata_q;
    assign err       = resp_valid & err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table, hand-written corner sequences and randomized traffic against a byte-level model
module tb_lsu;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memw;
        int          rdly;
        int          adly;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, err;
    logic [31:0] rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .rdata          (rdata),
        .err            (err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: natural alignment, byte ranges and plain arithmetic extension
    function automatic int nbytes(input logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic m_bad(input logic [1:0] s, input logic [31:0] a);
        return s == 2'd3 || (int'(a[1:0]) % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [1:0] s, input logic [31:0] a);
        logic [3:0] m;
        int lane = int'(a[1:0]);
        for (int i = 0; i < 4; i++) m[i] = (i >= lane) && (i < lane + nbytes(s));
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % nbytes(s)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] s, input logic uns, input logic [31:0] a, input logic [31:0] w);
        int          n    = nbytes(s);
        logic [63:0] keep = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v    = ({32'd0, w} >> (8 * int'(a[1:0]))) & keep;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~keep;
        return v[31:0];
    endfunction

    // Issue one request from IDLE and act as the memory, observing everything until the response
    task automatic run_txn(input string nm, input logic wen, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memw,
                           input int rdly, input int adly,
                           output logic [31:0] o_rdata, output logic o_err, output int o_cyc,
                           output logic [31:0] o_maddr, output logic [31:0] o_mwdata,
                           output logic o_mwen, output logic [3:0] o_mmask,
                           output int o_mreqs, output int o_pulses);
        int   rc = 0, wc = 0;
        logic waiting = 1'b0, seen = 1'b0;
        o_rdata = 'x; o_err = 1'bx; o_cyc = 0; o_maddr = '0; o_mwdata = '0;
        o_mwen = 1'b0; o_mmask = '0; o_mreqs = 0; o_pulses = 0;
        check({nm, ".ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = $urandom_range(0, 1); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 60; c++) begin
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = $urandom;
            if (resp_valid) begin
                if (o_pulses == 0) begin
                    o_cyc = c; o_rdata = rdata; o_err = err;
                end
                o_pulses++;
            end
            if (o_pulses > 0 && c == o_cyc + 1) begin
                check({nm, ".ready_after"}, req_ready, 1);
                break;
            end
            if (o_pulses == 0) check({nm, ".busy_ready"}, req_ready, 0);
            if (mem_req_valid) begin
                if (!seen) begin
                    o_maddr = mem_addr; o_mwdata = mem_wdata; o_mwen = mem_wen; o_mmask = mem_wmask;
                end else begin
                    check({nm, ".stable_addr"}, mem_addr, o_maddr);
                    check({nm, ".stable_wdata"}, mem_wdata, o_mwdata);
                    check({nm, ".stable_wen"}, mem_wen, o_mwen);
                    check({nm, ".stable_mask"}, mem_wmask, o_mmask);
                end
                seen = 1'b1;
                rc++;
                o_mreqs++;
                mem_req_ready = rc > rdly;
                waiting = mem_req_ready;
            end else if (waiting) begin
                mem_rdata = memw;
                mem_resp_valid = wc >= adly;
                if (mem_resp_valid) waiting = 1'b0;
                wc++;
            end
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    task automatic verify(input string nm, input logic wen, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memw,
                          input int rdly, input int adly,
                          input logic [31:0] e_rdata, input logic e_err,
                          input logic [31:0] e_wdata, input logic [3:0] e_mask);
        logic [31:0] g_rdata, g_maddr, g_mwdata;
        logic        g_err, g_mwen;
        logic [3:0]  g_mmask;
        int          g_cyc, g_mreqs, g_pulses;
        run_txn(nm, wen, size, uns, addr, wdata, memw, rdly, adly,
                g_rdata, g_err, g_cyc, g_maddr, g_mwdata, g_mwen, g_mmask, g_mreqs, g_pulses);
        check({nm, ".pulses"}, g_pulses, 1);
        check({nm, ".latency"}, g_cyc, e_err ? 1 : 3 + rdly + adly);
        check({nm, ".rdata"}, g_rdata, e_rdata);
        check({nm, ".err"}, g_err, e_err);
        if (e_err) check({nm, ".no_mem"}, g_mreqs, 0);
        else begin
            check({nm, ".mem_cycles"}, g_mreqs, rdly + 1);
            check({nm, ".mem_addr"}, g_maddr, {addr[31:2], 2'b00});
            check({nm, ".mem_wen"}, g_mwen, wen);
            check({nm, ".mem_wmask"}, g_mmask, e_mask);
            if (wen) check({nm, ".mem_wdata"}, g_mwdata, e_wdata);
        end
    endtask

    vec_t vecs[15];

    initial begin
        logic [31:0] a, w, m, prev;
        logic [1:0]  s;
        logic        we, u, be;
        int          rd, ad;

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1'b0, 32'h0,         4'b0000};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 1'b0, 32'h0,         4'b0000};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 32'h0000_0080, 1'b0, 32'h0,         4'b0000};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0,         32'h80FF_1234, 0, 0, 32'hFFFF_80FF, 1'b0, 32'h0,         4'b0000};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, 0, 32'h0,         1'b0, 32'hABCD_ABCD, 4'b1100};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0,         32'h1234_5678, 0, 0, 32'h0,         1'b1, 32'h0,         4'b0000};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,         32'h1234_5678, 0, 0, 32'h0,         1'b1, 32'h0,         4'b0000};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h1234_5678, 32'h0,         0, 0, 32'h0,         1'b0, 32'h7878_7878, 4'b0010};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0000, 32'h0,         32'h1234_F00D, 0, 0, 32'h0000_F00D, 1'b0, 32'h0,         4'b0000};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0000, 32'h0,         32'h1234_F00D, 1, 2, 32'hFFFF_F00D, 1'b0, 32'h0,         4'b0000};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'hCAFE_BABE, 32'h0,         0, 0, 32'h0,         1'b0, 32'hCAFE_BABE, 4'b1111};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h8000_0003, 32'h0,         32'h0,         0, 0, 32'h0,         1'b1, 32'h0,         4'b0000};
        vecs[12] = '{1'b0, 2'd2, 1'b1, 32'h8000_0010, 32'h0,         32'h8765_4321, 5, 4, 32'h8765_4321, 1'b0, 32'h0,         4'b0000};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h8000_0006, 32'h1122_3344, 32'h0,         0, 0, 32'h0,         1'b1, 32'h0,         4'b0000};
        vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h8000_000F, 32'h0000_00A5, 32'h0,         2, 1, 32'h0,         1'b0, 32'hA5A5_A5A5, 4'b1000};

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready", req_ready, 1);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.mem_req_valid", mem_req_valid, 0);
        check("rst.mem_wen", mem_wen, 0);
        check("rst.mem_wmask", mem_wmask, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        check("rst.rdata", rdata, 0);
        check("rst.err", err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            verify($sformatf("vec%0d", i), vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr,
                   vecs[i].wdata, vecs[i].memw, vecs[i].rdly, vecs[i].adly,
                   vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_wdata, vecs[i].e_mask);

        // Spurious memory responses while idle must not produce a response or disturb rdata
        prev = rdata;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1; mem_rdata = $urandom;
            @(posedge clk); #1;
            check("idle_spurious.resp_valid", resp_valid, 0);
            check("idle_spurious.req_ready", req_ready, 1);
            check("idle_spurious.rdata", rdata, prev);
        end
        mem_resp_valid = 1'b0;

        // Reset while waiting on memory: transaction is dropped and a late response is ignored
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8000_0020; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstwait.mem_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("rstwait.in_wait_req", mem_req_valid, 0);
        check("rstwait.in_wait_ready", req_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstwait.req_ready", req_ready, 1);
        check("rstwait.resp_valid", resp_valid, 0);
        check("rstwait.rdata", rdata, 0);
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
            @(posedge clk); #1;
            check("rstwait.late_resp_valid", resp_valid, 0);
            check("rstwait.late_ready", req_ready, 1);
            check("rstwait.late_rdata", rdata, 0);
        end
        mem_resp_valid = 1'b0;
        verify("after_rst", 1'b0, 2'd0, 1'b0, 32'h8000_0021, 32'h0, 32'h0000_7F00, 0, 0,
               32'h0000_007F, 1'b0, 32'h0, 4'b0000);

        // Randomized traffic checked against the byte-level model
        for (int i = 0; i < 250; i++) begin
            s  = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(s)) - 32'd1);
            w  = $urandom;
            m  = $urandom;
            rd = $urandom_range(0, 3);
            ad = $urandom_range(0, 3);
            be = m_bad(s, a);
            verify($sformatf("rnd%0d", i), we, s, u, a, w, m, rd, ad,
                   (be || we) ? 32'h0 : m_load(s, u, a, m), be,
                   m_wdata(s, w), we ? m_mask(s, a) : 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the single-cycle-style NPC core.
- Sits between execute/decode control and data memory. Produces the load data word that the ALU's load path forwards to writeback.
- Accepts one memory request at a time and aligns store data and byte masks onto a 32-bit memory port.
- Sign- or zero-extends load data, flags misaligned or illegal accesses without touching memory, and signals completion with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr
- DATA_W, 32, data width. Only 32 is supported; a compile-time check fails otherwise.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  DATA_W  extended load result, 0 for stores and errors
- err  out  1  misaligned/illegal flag, qualified by resp_valid
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  word-aligned address (req_addr with [1:0] = 0)
- mem_wen  out  1  memory write
- mem_wdata  out  DATA_W  lane-aligned store data
- mem_wmask  out  4  byte enables, 0 for loads
- mem_resp_valid  in  1  memory response / write ack
- mem_rdata  in  DATA_W  raw memory word

Behaviour:
- Reset: state IDLE; all outputs except req_ready are 0; req_ready = 1. Reset mid-transaction aborts it, drops any in-flight memory response, and emits no resp_valid.
- States: IDLE, REQ, WAIT, RESP.
- req_ready = (state == IDLE). Handshake fires on req_valid & req_ready; all req_* fields are registered at that edge.
- IDLE -> REQ on an accepted legal request. IDLE -> RESP directly on an accepted request that is misaligned or illegal.
- Misaligned/illegal conditions:
  - size 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - On error: err = 1, rdata = 0, no memory access.
- REQ: mem_req_valid = 1. mem_addr, mem_wen, mem_wdata and mem_wmask hold stable until mem_req_ready. REQ -> WAIT on mem_req_ready.
- WAIT: on mem_resp_valid, capture the extended load data (stores capture 0), then go to RESP. Stall indefinitely otherwise.
- mem_resp_valid outside WAIT is ignored.
- RESP: resp_valid = 1 for exactly one cycle; rdata and err are valid. Next state is IDLE. rdata holds its value until the next response.
- Minimum latency with zero-wait memory: accept at edge 0, REQ at cycle 1, WAIT at cycle 2, RESP at cycle 3. Error path reaches RESP at cycle 1.
- Store alignment, with lane = addr[1:0]:
  - byte: wdata[7:0] replicated on all 4 lanes; wmask = 1 << lane
  - half: wdata[15:0] replicated; wmask = 0011 for lane 0, 1100 for lane 2
  - word: data as-is; wmask = 1111
- Load extraction: select byte/half at the lane, then sign-extend from bit 7/15 unless req_unsigned. Word loads ignore req_unsigned.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_BAD
  - state enum IDLE/REQ/WAIT/RESP
  - a misalign-check function
- Sub-module lsu_align (combinational) holds:
  - store path: size, lane and wdata in; mem_wdata and mem_wmask out
  - load path: size, lane, unsigned flag and raw word in; extended rdata out
- The FSM and registers stay in lsu.

Test Plan:
- Word load at 0x80000004, mem_rdata = 0xDEADBEEF, zero-wait memory -> mem_addr = 0x80000004, wmask = 0000; resp_valid on cycle 3 with rdata = 0xDEADBEEF, err = 0.
- lb at 0x80000003 with mem_rdata = 0x80FF1234 -> rdata = 0xFFFFFF80. The same access as lbu -> 0x00000080. lh at offset 2 -> 0xFFFF80FF.
- sh at 0x80000002 with wdata = 0x0000ABCD -> mem_wdata = 0xABCDABCD, wmask = 1100, mem_wen = 1. After ack, rdata = 0.
- Word load at 0x80000001 -> no mem_req_valid, resp_valid at cycle 1 with err = 1 and rdata = 0. A size-3 request gives the same result.
- mem_req_ready held low 5 cycles and mem_resp_valid delayed 4 cycles -> mem_* outputs stay stable, req_ready = 0 throughout, exactly one resp_valid pulse. A spurious mem_resp_valid in IDLE is ignored.
- rst asserted while in WAIT -> next cycle state IDLE, req_ready = 1, no resp_valid. A later mem_resp_valid is ignored.
